sp_frame_scheduler: RTL and testbench

SP_FRAME_SCHEDULER -- requirements
Module: sp_frame_scheduler

---
 rtl/sp_frame_scheduler.sv | 152 +++++++++++++++
 tb/tb_sp_frame_scheduler.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sp_frame_scheduler.sv
// ============================================================================
// Module   : sp_frame_scheduler
// Purpose  : Round-robin arbiter that feeds whole frames from one of several
//            serial sources into a shared serial-to-parallel converter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sp_frame_scheduler #(
  parameter int NUM_SRC         = 4,
  parameter int SERIAL_LENGTH   = 1,
  parameter int PARALLEL_LENGTH = 32,
  localparam int SRC_IDW        = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_SRC-1:0]                      src_en,
  input  logic [NUM_SRC-1:0]                      src_valid,
  input  logic [NUM_SRC-1:0][SERIAL_LENGTH*32-1:0] src_data,
  output logic [NUM_SRC-1:0]                      src_ready,
  input  logic                                    dst_hold,
  output logic                                    cv_ien,
  output logic [SERIAL_LENGTH*32-1:0]             cv_idata,
  output logic                                    cv_fct,
  input  logic                                    cv_oen,
  output logic [SRC_IDW-1:0]                      out_src_id,
  output logic                                    busy,
  output logic [NUM_SRC-1:0][15:0]                frame_cnt
);

  localparam int c_beats = PARALLEL_LENGTH / SERIAL_LENGTH;
  localparam int c_bcw   = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam logic [c_bcw-1:0]   c_last_beat = c_bcw'(c_beats - 1);
  localparam logic [SRC_IDW-1:0] c_last_src  = SRC_IDW'(NUM_SRC - 1);
  localparam logic [SRC_IDW:0]   c_num_src   = (SRC_IDW + 1)'(NUM_SRC);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_XFER     = 2'd1,
    S_WAIT_OUT = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_nxt;
  logic [SRC_IDW-1:0]        r_grant;
  logic [SRC_IDW-1:0]        r_rr_ptr;
  logic [c_bcw-1:0]          r_beat_cnt;
  logic [NUM_SRC-1:0][15:0]  r_frame_cnt;

  logic [NUM_SRC-1:0]        w_elig;
  logic [SRC_IDW:0]          w_idx;
  logic [SRC_IDW-1:0]        w_pick;
  logic                      w_found;
  logic                      w_start;
  logic                      w_accept;
  logic                      w_last;
  logic                      w_done;

  assign w_elig = src_valid & src_en;

  // Scan upward from the round-robin pointer, wrapping modulo NUM_SRC.
  always_comb begin : p_rr_search
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (SRC_IDW + 1)'(k);
      if (w_idx >= c_num_src) begin
        w_idx = w_idx - c_num_src;
      end
      if (!w_found && w_elig[w_idx[SRC_IDW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = w_idx[SRC_IDW-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_state_reg
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin : p_fsm
    w_state_nxt = r_state;
    src_ready   = '0;
    cv_ien      = 1'b0;
    w_start     = 1'b0;
    w_accept    = 1'b0;
    w_last      = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_start     = 1'b1;
          w_state_nxt = S_XFER;
        end
      end
      S_XFER: begin
        src_ready[r_grant] = 1'b1;
        cv_ien             = src_valid[r_grant];
        w_accept           = src_valid[r_grant];
        if (w_accept && (r_beat_cnt == c_last_beat)) begin
          w_last      = 1'b1;
          w_state_nxt = S_WAIT_OUT;
        end
      end
      S_WAIT_OUT: begin
        if (cv_oen) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Grant is captured only on leaving IDLE, so the owner is locked for the frame.
  always_ff @(posedge clk or negedge rst_n) begin : p_datapath
    if (!rst_n) begin
      r_grant     <= '0;
      r_rr_ptr    <= '0;
      r_beat_cnt  <= '0;
      r_frame_cnt <= '0;
    end else begin
      if (w_start) begin
        r_grant    <= w_pick;
        r_beat_cnt <= '0;
      end
      if (w_accept) begin
        r_beat_cnt <= r_beat_cnt + 1'b1;
      end
      if (w_last) begin
        r_rr_ptr <= (r_grant == c_last_src) ? '0 : r_grant + 1'b1;
      end
      if (w_done) begin
        r_frame_cnt[r_grant] <= r_frame_cnt[r_grant] + 16'd1;
      end
    end
  end

  assign cv_idata   = src_data[r_grant];
  assign cv_fct     = dst_hold;
  assign busy       = (r_state != S_IDLE);
  assign out_src_id = r_grant;
  assign frame_cnt  = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_sp_frame_scheduler.sv
// ============================================================================
// Module   : tb_sp_frame_scheduler
// Purpose  : Directed + randomized bench for sp_frame_scheduler with a
//            frame-level reference model and a converter stand-in.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sp_frame_scheduler;
  localparam int NUM_SRC         = 4;
  localparam int SERIAL_LENGTH   = 1;
  localparam int PARALLEL_LENGTH = 32;
  localparam int BEATS           = PARALLEL_LENGTH / SERIAL_LENGTH;
  localparam int IDW             = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  logic                                    clk;
  logic                                    rst_n;
  logic [NUM_SRC-1:0]                      src_en;
  logic [NUM_SRC-1:0]                      src_valid;
  logic [NUM_SRC-1:0][SERIAL_LENGTH*32-1:0] src_data;
  logic [NUM_SRC-1:0]                      src_ready;
  logic                                    dst_hold;
  logic                                    cv_ien;
  logic [SERIAL_LENGTH*32-1:0]             cv_idata;
  logic                                    cv_fct;
  logic                                    cv_oen;
  logic [IDW-1:0]                          out_src_id;
  logic                                    busy;
  logic [NUM_SRC-1:0][15:0]                frame_cnt;

  sp_frame_scheduler #(
    .NUM_SRC        (NUM_SRC),
    .SERIAL_LENGTH  (SERIAL_LENGTH),
    .PARALLEL_LENGTH(PARALLEL_LENGTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .src_en    (src_en),
    .src_valid (src_valid),
    .src_data  (src_data),
    .src_ready (src_ready),
    .dst_hold  (dst_hold),
    .cv_ien    (cv_ien),
    .cv_idata  (cv_idata),
    .cv_fct    (cv_fct),
    .cv_oen    (cv_oen),
    .out_src_id(out_src_id),
    .busy      (busy),
    .frame_cnt (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: mode 0 = waiting for a request, 1 = moving a frame, 2 = frame handed off
  int          m_mode, m_grant, m_ptr, m_beats, m_done;
  logic [15:0] m_cnt [NUM_SRC];
  bit          m_new_frame;

  int  conv_cnt;
  bit  conv_pend, obs_ien, spurious_en, valid_rand, hold_rand, seen02;
  int  cnt_ien;
  int  q_grants[$];
  logic [NUM_SRC-1:0][15:0] fv;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_grant = 0; m_ptr = 0; m_beats = 0; m_new_frame = 0;
    for (int i = 0; i < NUM_SRC; i++) m_cnt[i] = 16'd0;
  endtask

  task automatic conv_reset();
    conv_cnt = 0; conv_pend = 0; cv_oen = 1'b0; obs_ien = 0;
  endtask

  task automatic model_step();
    logic [NUM_SRC-1:0] el;
    bit found;
    if (!rst_n) begin
      model_reset();
    end else begin
      case (m_mode)
        0: begin
          el = src_valid & src_en;
          found = 0;
          for (int k = 0; k < NUM_SRC; k++) begin
            if (!found && el[(m_ptr + k) % NUM_SRC]) begin
              found = 1;
              m_grant = (m_ptr + k) % NUM_SRC;
            end
          end
          if (found) begin
            m_mode = 1; m_beats = 0; m_new_frame = 1;
          end
        end
        1: begin
          if (src_valid[m_grant]) begin
            m_beats++;
            if (m_beats == BEATS) begin
              m_mode = 2;
              m_ptr  = (m_grant + 1) % NUM_SRC;
            end
          end
        end
        default: begin
          if (cv_oen) begin
            m_cnt[m_grant] = m_cnt[m_grant] + 16'd1;
            m_mode = 0;
            m_done++;
          end
        end
      endcase
    end
  endtask

  task automatic check_outputs();
    logic [NUM_SRC-1:0] er;
    er = '0;
    if (m_mode == 1) er[m_grant] = 1'b1;
    chk("src_ready", src_ready, er);
    chk("cv_ien", cv_ien, (m_mode == 1) && src_valid[m_grant]);
    if ((m_mode == 1) && src_valid[m_grant]) chk("cv_idata", cv_idata, src_data[m_grant]);
    chk("busy", busy, m_mode != 0);
    chk("cv_fct", cv_fct, dst_hold);
    if (m_mode != 0) chk("out_src_id", out_src_id, m_grant);
    for (int i = 0; i < NUM_SRC; i++) chk($sformatf("frame_cnt[%0d]", i), frame_cnt[i], m_cnt[i]);
    obs_ien = (cv_ien === 1'b1);
    if (obs_ien) cnt_ien++;
    if (src_ready[0] === 1'b1 || src_ready[2] === 1'b1) seen02 = 1;
    if (m_new_frame) begin
      q_grants.push_back(int'(out_src_id));
      m_new_frame = 0;
    end
  endtask

  // Converter stand-in: emits its frame-valid pulse the cycle after the last beat unless held.
  task automatic conv_step();
    if (!rst_n) begin
      conv_reset();
    end else begin
      cv_oen = 1'b0;
      if (obs_ien) conv_cnt++;
      if (conv_cnt == BEATS) begin
        conv_cnt  = 0;
        conv_pend = 1;
      end
      if (conv_pend && !dst_hold) begin
        cv_oen    = 1'b1;
        conv_pend = 0;
      end else if (spurious_en && m_mode != 2 && $urandom_range(0, 15) == 0) begin
        cv_oen = 1'b1;
      end
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < NUM_SRC; i++)
      for (int w = 0; w < SERIAL_LENGTH; w++) src_data[i][w*32 +: 32] = $urandom;
    if (valid_rand)
      for (int i = 0; i < NUM_SRC; i++) src_valid[i] = ($urandom_range(0, 9) < 7);
    if (hold_rand) dst_hold = ($urandom_range(0, 4) == 0);
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
    conv_step();
    refresh();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    conv_reset();
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_frames(input string tag, input int n, input int budget, output int cyc);
    int target;
    target = m_done + n;
    cyc = 0;
    while (m_done < target && cyc < budget) begin
      tick();
      cyc++;
    end
    chk({tag, "_timeout"}, m_done >= target, 1);
  endtask

  task automatic check_grants(input string tag, input int e0, input int e1, input int e2,
                              input int e3, input int e4, input int n);
    int exp_g[5];
    exp_g = '{e0, e1, e2, e3, e4};
    chk({tag, "_frames"}, q_grants.size() >= n, 1);
    for (int i = 0; i < n; i++)
      chk($sformatf("%s_grant%0d", tag, i), (i < q_grants.size()) ? q_grants[i] : -1, exp_g[i]);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    src_en = '0; src_valid = '0; src_data = '0; dst_hold = 1'b0;
    spurious_en = 0; valid_rand = 0; hold_rand = 0; seen02 = 0; cnt_ien = 0;
    m_done = 0;

    // Reset state
    do_reset();
    chk("rst_out_src_id", out_src_id, 0);
    chk("rst_busy", busy, 0);

    // Single source, continuous valid
    src_en = '1; src_valid = 4'b0001; cnt_ien = 0; q_grants.delete();
    wait_frames("p1", 1, 200, cyc);
    chk("p1_frame_cycles", cyc, BEATS + 2);
    chk("p1_ien_pulses", cnt_ien, BEATS);
    chk("p1_idle_after", busy, 0);
    chk("p1_cnt0", frame_cnt[0], 1);
    chk("p1_grant", (q_grants.size() > 0) ? q_grants[0] : -1, 0);
    src_valid = '0;

    // All sources requesting: round-robin order
    do_reset();
    src_en = '1; src_valid = '1; q_grants.delete();
    wait_frames("p2", 5, 400, cyc);
    check_grants("p2", 0, 1, 2, 3, 0, 5);
    src_valid = '0;

    // Downstream hold across the last beat
    do_reset();
    src_en = '1; src_valid = 4'b0100;
    cyc = 0;
    while (!(m_mode == 1 && m_beats == BEATS - 1) && cyc < 200) begin tick(); cyc++; end
    dst_hold = 1'b1;
    while (m_mode != 2 && cyc < 200) begin tick(); cyc++; end
    chk("p3_reach_wait", m_mode, 2);
    repeat (10) tick();
    chk("p3_hold_busy", busy, 1);
    chk("p3_hold_fct", cv_fct, 1);
    chk("p3_cnt_held", frame_cnt[2], 0);
    dst_hold = 1'b0;
    wait_frames("p3", 1, 20, cyc);
    chk("p3_release_latency", cyc, 2);
    chk("p3_cnt2", frame_cnt[2], 1);
    src_valid = '0;

    // Only sources 1 and 3 enabled
    do_reset();
    src_en = 4'b1010; src_valid = '1; q_grants.delete(); seen02 = 0;
    wait_frames("p4", 4, 300, cyc);
    check_grants("p4", 1, 3, 1, 3, 0, 4);
    chk("p4_ready02_never", seen02, 0);
    src_valid = '0;

    // Asynchronous reset in the middle of a frame
    do_reset();
    src_en = '1; src_valid = '1;
    cyc = 0;
    while (!(m_mode == 1 && m_beats == 17) && cyc < 200) begin tick(); cyc++; end
    chk("p5_reach_beat17", m_beats, 17);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("p5_rst_ready", src_ready, 0);
    chk("p5_rst_ien", cv_ien, 0);
    chk("p5_rst_busy", busy, 0);
    chk("p5_rst_id", out_src_id, 0);
    chk("p5_rst_cnt", frame_cnt, 0);
    model_reset();
    conv_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    q_grants.delete();
    wait_frames("p5", 1, 100, cyc);
    chk("p5_restart_grant", (q_grants.size() > 0) ? q_grants[0] : -1, 0);
    chk("p5_cnt0", frame_cnt[0], 1);
    src_valid = '0;

    // Randomized traffic with changing enables, holds and stray frame pulses
    valid_rand = 1; hold_rand = 1; spurious_en = 1;
    for (int seg = 0; seg < 8; seg++) begin
      src_en = NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1));
      repeat (400) tick();
    end
    valid_rand = 0; hold_rand = 0; spurious_en = 0; dst_hold = 1'b0; src_valid = '1;
    cyc = 0;
    while (m_mode != 2 && cyc < 100) begin tick(); cyc++; end
    src_valid = '0;
    while (m_mode != 0 && cyc < 200) begin tick(); cyc++; end
    chk("p6_drained", m_mode, 0);

    // Counter wrap: preload source 2 counter near full scale
    for (int i = 0; i < NUM_SRC; i++) fv[i] = m_cnt[i];
    fv[2] = 16'hFFFF;
    m_cnt[2] = 16'hFFFF;
    force dut.r_frame_cnt = fv;
    tick();
    release dut.r_frame_cnt;
    tick();
    src_en = '1; src_valid = 4'b0100;
    wait_frames("p7", 1, 100, cyc);
    chk("p7_wrap", frame_cnt[2], 0);
    src_valid = '0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
